// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte port among NUM_REQ byte streams.
// Grants are held per packet (until req_last) or until MAX_BURST bytes have passed.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_data_valid,
  input  logic                        tx_data_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Handshake: a byte moves on a rising edge where valid and ready are both 1,
  // on every requester port and on the tx port; senders hold data/valid/last until then.
  state_e             state_q;
  logic [GID_W-1:0]   grant_q;
  logic [GID_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   burst_q;
  logic [CNT_W-1:0]   burst_d;
  logic [DATA_W-1:0]  tx_data_q;
  logic               tx_valid_q;

  logic [GID_W-1:0]   sel_idx;
  logic [GID_W-1:0]   cand;
  logic               sel_found;
  logic [DATA_W-1:0]  owner_data;
  logic               owner_last;
  logic               owner_ready;
  logic               req_xfer;
  logic               tx_xfer;
  logic               limit_hit;

  // First valid requester searching upward from the one after the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign owner_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign owner_last  = req_last[grant_q];
  // The output register accepts a new byte when empty or draining this cycle,
  // so a new owner never overtakes the previous owner's final byte.
  assign owner_ready = (state_q == GRANT) & (~tx_valid_q | tx_data_ready);
  assign req_xfer    = owner_ready & req_valid[grant_q];
  assign tx_xfer     = tx_valid_q & tx_data_ready;
  assign burst_d     = (&burst_q) ? burst_q : burst_q + 1'b1;
  assign limit_hit   = (MAX_BURST != 0) && (burst_d == CNT_W'(MAX_BURST));

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = owner_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      burst_q      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      if (tx_xfer) begin
        tx_valid_q <= 1'b0;
      end
      if (req_xfer) begin
        tx_data_q  <= owner_data;
        tx_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            burst_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req_xfer) begin
            burst_q <= burst_d;
            if (owner_last || limit_hit) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == GRANT) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-scenario tasks drive requesters, a negedge
// monitor pops expected tx bytes from a queue in strict order.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_data_valid;
  logic                       tx_data_ready;
  logic [1:0]                 grant_id;
  logic                       busy;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_b;
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion within 500000 ns");
    $fatal(1);
  end

  // Scoreboard: a tx transfer happens at the posedge following this negedge
  always @(negedge clk) begin
    if (!rst && tx_data_valid && tx_data_ready) begin
      n_out++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_byte: got %02h, required no byte", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          n_err++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_byte(input int id, input logic [7:0] b, input logic last, input int budget);
    int cyc;
    bit ok;
    req_data[id*8 +: 8] = b;
    req_valid[id]       = 1'b1;
    req_last[id]        = last;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_ready[id] === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL req%0d_accept: byte %02h not accepted after %0d cycles, required acceptance", id, b, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int id, input logic [7:0] b[4], input int n, input logic with_last,
                          input int budget);
    for (int i = 0; i < n; i++) drive_byte(id, b[i], with_last && (i == n - 1), budget);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || tx_data_valid !== 1'b0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0 || tx_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: %0d bytes outstanding, tx_data_valid=%b, required 0 and 0",
               name, exp_q.size(), tx_data_valid);
    end
    @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    rst = 1'b1;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    tx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
    n_vec++; if (tx_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b, required 0", tx_data_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b, required 0", busy); end
    // Requester 0 must win the first round over requester 3
    pa = '{8'h01, 8'h00, 8'h00, 8'h00};
    pb = '{8'h31, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h31);
    fork
      send_pkt(0, pa, 1, 1'b1, 50);
      send_pkt(3, pb, 1, 1'b1, 50);
    join
    wait_drain("reset_priority", 50);
  endtask

  task automatic test_single();
    logic [7:0] p[4];
    p = '{8'h41, 8'h42, 8'h43, 8'h00};
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    send_pkt(2, p, 3, 1'b1, 50);
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d, required 2", grant_id); end
    n_vec++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h43) begin
      n_err++; $display("FAIL single_last_byte: got valid=%b data=%02h, required valid=1 data=43", tx_data_valid, tx_data);
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hold: got %b, required 1", busy); end
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got %b, required 0", busy); end
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant_kept: got %0d, required 2", grant_id); end
    wait_drain("single", 20);
  endtask

  task automatic test_contention();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    logic [7:0] pc[4];
    logic [7:0] pd[4];
    pa = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    pb = '{8'h3C, 8'hC3, 8'h00, 8'h00};
    pc = '{8'h11, 8'h00, 8'h00, 8'h00};
    pd = '{8'h22, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin send_pkt(0, pa, 2, 1'b1, 100); send_pkt(0, pc, 1, 1'b1, 100); end
      begin send_pkt(1, pb, 2, 1'b1, 100); send_pkt(1, pd, 1, 1'b1, 100); end
    join
    n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL contention_grant: got %0d, required 1", grant_id); end
    wait_drain("contention", 50);
  endtask

  task automatic test_backpressure();
    logic [7:0] p[4];
    int bad;
    int cyc;
    p = '{8'h77, 8'h88, 8'h00, 8'h00};
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h88);
    tx_data_ready = 1'b0;
    bad = 0;
    fork
      send_pkt(3, p, 2, 1'b1, 2000);
      begin
        cyc = 0;
        while (tx_data_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_vec++;
        if (tx_data_valid !== 1'b1) begin
          n_err++; $display("FAIL bp_first_byte: got valid=%b, required 1", tx_data_valid);
        end
        repeat (1000) begin
          @(negedge clk);
          if (tx_data_valid !== 1'b1 || tx_data !== 8'h77 || req_ready !== 4'b0000) bad++;
        end
        @(posedge clk);
        #1 tx_data_ready = 1'b1;
      end
    join
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", bad); end
    wait_drain("backpressure", 50);
  endtask

  task automatic test_burst();
    logic [7:0] p[4];
    p = '{8'hE0, 8'hE1, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE1);
    for (int i = 4; i < 10; i++) exp_q.push_back(8'(8'h10 + i));
    fork
      begin
        for (int i = 0; i < 10; i++) drive_byte(0, 8'(8'h10 + i), 1'b0, 200);
        req_valid[0] = 1'b0;
      end
      send_pkt(3, p, 2, 1'b1, 200);
    join
    wait_drain("burst", 50);
    // Req 0 stopped without last after 2 bytes of its burst: grant stays put
    req_data[31:24] = 8'h99;
    req_valid[3]    = 1'b1;
    req_last[3]     = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL burst_hold_busy: got %b, required 1", busy); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL burst_hold_grant: got %0d, required 0", grant_id); end
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL burst_hold_ready: got %b, required 0001", req_ready); end
    req_valid[3] = 1'b0;
    req_last[3]  = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[4];
    int mark;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h51);
    drive_byte(1, 8'h51, 1'b0, 50);
    drive_byte(1, 8'h52, 1'b0, 50);
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    @(posedge clk);
    #1;
    n_vec++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_err++; $display("FAIL rstmid_tx: got valid=%b data=%02h, required valid=0 data=00", tx_data_valid, tx_data);
    end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready: got %b, required 0000", req_ready); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid_grant: got %0d, required 0", grant_id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    rst = 1'b0;
    mark = n_out;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (n_out != mark) begin n_err++; $display("FAIL rstmid_quiet: got %0d bytes, required 0", n_out - mark); end
    p = '{8'hFF, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'hFF);
    send_pkt(1, p, 1, 1'b1, 50);
    wait_drain("reset_mid", 20);
    n_vec++; if (n_out != mark + 1) begin n_err++; $display("FAIL rstmid_count: got %0d bytes, required 1", n_out - mark); end
  endtask

  task automatic test_end_to_end();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    int got;
    int cyc;
    pa = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    pb = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    // Last owner was requester 1, so requester 2 goes first
    for (int i = 0; i < 4; i++) exp_q.push_back(pb[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(pa[i]);
    got = 0;
    fork
      send_pkt(0, pa, 4, 1'b1, 1000);
      send_pkt(2, pb, 4, 1'b1, 1000);
      begin
        cyc = 0;
        tx_data_ready = 1'b1;
        while (got < 8 && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (tx_data_valid === 1'b1 && tx_data_ready === 1'b1) begin
            got++;
            @(posedge clk);
            #1 tx_data_ready = 1'b0;
            repeat ($urandom_range(20, 40)) @(posedge clk);
            #1 tx_data_ready = 1'b1;
          end
        end
      end
    join
    n_vec++; if (got != 8) begin n_err++; $display("FAIL e2e_count: got %0d bytes, required 8", got); end
    wait_drain("end_to_end", 50);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_burst();
    test_reset_mid();
    test_end_to_end();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_queue: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
